irq_scheduler: RTL

IRQ_SCHEDULER -- requirements
Module: irq_scheduler

---
 rtl/irq_scheduler.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/irq_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : irq_scheduler
// Purpose  : Periodic interrupt scheduler. NCH free-running period counters
//            raise per-channel pending flags. A round-robin arbiter presents
//            one pending channel at a time on a level irq with its id, and
//            guarantees a one-cycle low gap after every acknowledge.
//            Overruns (an event on an already-pending channel) are counted
//            in a saturating 16-bit counter.
// Revision : 1.0 - initial release
// ============================================================================
module irq_scheduler #(
  parameter int NCH = 4,
  parameter int CW  = 32
) (
  input  logic                   axi_aclk,
  input  logic                   axi_aresetn,
  input  logic [NCH*CW-1:0]      cfg_period,
  input  logic [NCH-1:0]         cfg_enable,
  input  logic                   irq_ack,
  output logic                   irq,
  output logic [$clog2(NCH)-1:0] irq_id,
  output logic [NCH-1:0]         pend,
  output logic [15:0]            overrun_count
);

  localparam int c_IDW = $clog2(NCH);
  localparam int c_PCW = $clog2(NCH + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ASSERT = 2'd1,
    S_GAP    = 2'd2
  } state_t;

  state_t             r_state;
  logic [c_IDW-1:0]   r_last;

  logic [NCH-1:0]     w_event;
  logic [NCH-1:0]     w_clr;
  logic [NCH-1:0]     w_ovr;
  logic [NCH-1:0]     w_pend_nxt;
  logic [c_PCW-1:0]   w_ovr_n;
  logic [16:0]        w_ovr_sum;
  logic               w_found;
  logic [c_IDW-1:0]   w_sel;
  logic [c_IDW-1:0]   w_idx;

  // --------------------------------------------------------------------------
  // Per-channel period counters and terminal-count events
  // --------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      logic [CW-1:0] w_per;
      logic [CW-1:0] w_term;
      logic [CW-1:0] r_cnt;

      assign w_per  = cfg_period[gi*CW +: CW];
      assign w_term = w_per - CW'(1);
      // A zero period never fires; the guard also hides the underflowed w_term.
      assign w_event[gi] = cfg_enable[gi] && (w_per != '0) && (r_cnt == w_term);

      // Count 0..period-1 while enabled; park at 0 when disabled or period==0.
      // A count already beyond the terminal value wraps silently.
      always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
          r_cnt <= '0;
        end else if (!cfg_enable[gi] || (w_per == '0) || (r_cnt >= w_term)) begin
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Pending flags and overrun accounting
  // --------------------------------------------------------------------------
  // An acknowledge clears only the channel being presented.
  assign w_clr = ((r_state == S_ASSERT) && irq_ack)
               ? ({{(NCH-1){1'b0}}, 1'b1} << irq_id) : '0;

  // A new event wins over a same-cycle clear and is not an overrun.
  assign w_pend_nxt = w_event | (pend & ~w_clr);
  assign w_ovr      = w_event & pend & ~w_clr;

  // Population count of simultaneous overruns this cycle.
  always_comb begin
    w_ovr_n = '0;
    for (int k = 0; k < NCH; k++) begin
      w_ovr_n = w_ovr_n + {{(c_PCW-1){1'b0}}, w_ovr[k]};
    end
  end

  assign w_ovr_sum = {1'b0, overrun_count} + {{(17-c_PCW){1'b0}}, w_ovr_n};

  // Register pending flags and the saturating overrun counter.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      pend          <= '0;
      overrun_count <= '0;
    end else begin
      pend          <= w_pend_nxt;
      overrun_count <= w_ovr_sum[16] ? 16'hFFFF : w_ovr_sum[15:0];
    end
  end

  // --------------------------------------------------------------------------
  // Round-robin search starting one past the last served channel
  // --------------------------------------------------------------------------
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_idx   = '0;
    for (int i = 1; i <= NCH; i++) begin
      w_idx = c_IDW'((int'(r_last) + i) % NCH);
      if (!w_found && pend[w_idx]) begin
        w_found = 1'b1;
        w_sel   = w_idx;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Arbiter FSM with registered irq / irq_id
  // --------------------------------------------------------------------------
  // The GAP cycle holds irq low and also performs the search, so the low
  // time between back-to-back assertions is exactly one cycle.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      r_state <= S_IDLE;
      irq     <= 1'b0;
      irq_id  <= '0;
      r_last  <= c_IDW'(NCH - 1);
    end else begin
      case (r_state)
        S_IDLE, S_GAP: begin
          if (w_found) begin
            irq     <= 1'b1;
            irq_id  <= w_sel;
            r_state <= S_ASSERT;
          end else begin
            irq     <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_ASSERT: begin
          // Wait for software even if the channel has been disabled meanwhile.
          if (irq_ack) begin
            irq     <= 1'b0;
            r_last  <= irq_id;
            r_state <= S_GAP;
          end
        end
        default: begin
          irq     <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
